// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_pkg : shared state type and RISC-V funct3 encodings    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_lane_align : access check, store lane merge, load extraction     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic        err,
    output logic [3:0]  byte_en,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic        w_illegal;
    logic        w_misalign;
    logic [3:0]  w_lanes;
    logic [31:0] w_wpos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = mem_word[8*addr_lo +: 8];
    assign w_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        w_lanes    = 4'b0000;
        w_wpos     = wdata;
        load_data  = '0;
        case (funct3)
            F3_B: begin
                w_lanes   = 4'b0001 << addr_lo;
                w_wpos    = {4{wdata[7:0]}};
                load_data = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                w_misalign = addr_lo[0];
                w_lanes    = addr_lo[1] ? 4'b1100 : 4'b0011;
                w_wpos     = {2{wdata[15:0]}};
                load_data  = {{16{w_half[15]}}, w_half};
            end
            F3_W: begin
                w_misalign = (addr_lo != 2'b00);
                w_lanes    = 4'b1111;
                load_data  = mem_word;
            end
            F3_BU: begin
                w_illegal = we;
                load_data = {24'd0, w_byte};
            end
            F3_HU: begin
                w_illegal  = we;
                w_misalign = addr_lo[0];
                load_data  = {16'd0, w_half};
            end
            default: w_illegal = 1'b1;
        endcase
        err     = w_illegal | w_misalign;
        byte_en = (we && !err) ? w_lanes : 4'b0000;
        if (err || we) begin
            load_data = '0;
        end
    end

    // Sub-word store data is replicated across lanes so the enable alone picks the target bytes.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign merged[8*k +: 8] = byte_en[k] ? w_wpos[8*k +: 8] : mem_word[8*k +: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : fixed-latency load/store responder for the MEM stage |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int DEPTH = 1 << (DM_ADDRESS - 2);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_funct3;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic [DM_ADDRESS-3:0] w_idx;
    logic [DATA_W-1:0]     w_word;
    logic                  w_err;
    logic [3:0]            w_byte_en;
    logic [DATA_W-1:0]     w_merged;
    logic [DATA_W-1:0]     w_load;
    logic                  w_accept;

    assign w_idx    = r_addr[DM_ADDRESS-1:2];
    assign w_word   = r_mem[w_idx];
    assign w_accept = req_valid && req_ready;

    assign req_ready = (r_state != WAIT);
    assign busy      = (r_state == WAIT);
    assign rsp_valid = (r_state == RESP);

    dmem_lane_align u_lane_align (
        .we        (r_we),
        .addr_lo   (r_addr[1:0]),
        .funct3    (r_funct3),
        .wdata     (r_wdata),
        .mem_word  (w_word),
        .err       (w_err),
        .byte_en   (w_byte_en),
        .merged    (w_merged),
        .load_data (w_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                WAIT: begin
                    if (r_cnt == '0) begin
                        rsp_rdata <= w_load;
                        rsp_err   <= w_err;
                        if (|w_byte_en) begin
                            r_mem[w_idx] <= w_merged;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    // IDLE and RESP both accept; RESP falls back to IDLE when nothing is offered.
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_cnt    <= CNT_LOAD;
                        r_state  <= WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
